uart_tx_arbiter: RTL

Shares one 8N1 UART transmit line between NUM_REQ byte sources using round-robin arbitration. Sequences the baud tick generator by driving its enable. Advances the bit shifter on each returned tick. Sits between the on-chip byte producers and the txd pin, next to the baud tick generator instance that it controls.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
package uart_pkg;

    // Level driven on txd when no frame is in flight (also the stop bit).
    localparam logic        UART_IDLE_LEVEL   = 1'b1;
    localparam int unsigned DATA_BITS_DEFAULT = 8;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] hi_gnt;
    logic [NUM_REQ-1:0] lo_gnt;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;

    // Lowest set bit at/above the pointer wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_mask = '0;
        hi_gnt  = '0;
        lo_gnt  = '0;
        hi_id   = '0;
        lo_id   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            hi_mask[i] = (i >= int'(rr_ptr));
        end
        hi_req = req & hi_mask;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                hi_gnt    = '0;
                hi_gnt[i] = 1'b1;
                hi_id     = ID_W'(i);
            end
            if (req[i]) begin
                lo_gnt    = '0;
                lo_gnt[i] = 1'b1;
                lo_id     = ID_W'(i);
            end
        end
        gnt_valid = |req;
        gnt       = (|hi_req) ? hi_gnt : lo_gnt;
        gnt_id    = (|hi_req) ? hi_id  : lo_id;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between NUM_REQ byte sources.
// Drives the external baud generator's enable and advances one bit per returned tick.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT,
    parameter int unsigned ID_W      = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           baud_en,
    input  logic                           baud_tick,
    output logic                           txd,
    output logic                           busy,
    output logic [ID_W-1:0]                grant_id
);

    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t              state_q,   state_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [ID_W-1:0]        ptr_q,     ptr_d;
    logic [ID_W-1:0]        grant_q,   grant_d;
    logic [NUM_REQ-1:0]     ready_q,   ready_d;
    logic                   txd_q,     txd_d;
    logic                   baud_en_q, baud_en_d;
    logic                   busy_q,    busy_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [ID_W-1:0]        arb_id;
    logic                   arb_valid;
    logic [DATA_BITS-1:0]   sel_data;
    logic [ID_W-1:0]        ptr_next;
    logic                   do_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (ptr_q),
        .gnt       (arb_gnt),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    // Select the granted requester's byte using the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_gnt[i]) begin
                sel_data = req_data[i*int'(DATA_BITS) +: DATA_BITS];
            end
        end
    end

    // Pointer moves one past the winner so it gets the lowest priority next round.
    always_comb begin
        if (arb_id == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = ID_W'(arb_id + ID_W'(1));
        end
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        txd_d     = txd_q;
        baud_en_d = baud_en_q;
        busy_d    = busy_q;
        ready_d   = '0;
        do_grant  = 1'b0;

        case (state_q)
            IDLE: begin
                // Ticks are ignored here; only a pending request starts a frame.
                if (arb_valid) begin
                    do_grant = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (cnt_q < CNT_W'(DATA_BITS - 1)) begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                    end else begin
                        state_d = STOP;
                        txd_d   = UART_IDLE_LEVEL;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    // A waiting requester starts immediately: no idle gap between frames.
                    if (arb_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        baud_en_d = 1'b0;
                        busy_d    = 1'b0;
                        txd_d     = UART_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common grant actions: accept pulse, latch byte, advance pointer, begin start bit.
        if (do_grant) begin
            ready_d   = arb_gnt;
            shift_d   = sel_data;
            grant_d   = arb_id;
            ptr_d     = ptr_next;
            state_d   = START;
            txd_d     = ~UART_IDLE_LEVEL;
            baud_en_d = 1'b1;
            busy_d    = 1'b1;
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            txd_q     <= UART_IDLE_LEVEL;
            baud_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            ready_q   <= ready_d;
            txd_q     <= txd_d;
            baud_en_q <= baud_en_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign baud_en   = baud_en_q;
    assign txd       = txd_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule
